// File: rtl/cfg_spi_link.sv
// cfg_spi_link: SPI mode-0 slave that turns MCU frames into configuration
// register writes (57 addr data...) and status readback (52 addr xx...).
// Everything runs on clk28; the SPI pins are synchronized and edge-detected.
module cfg_spi_link #(
    parameter int SYNC_STAGES = 2,    // must be >= 2
    parameter int TIMEOUT     = 4095
) (
    input  logic       clk28,
    input  logic       rst_n,
    input  logic       spi_sck,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic [7:0] cfg_addr,
    output logic [7:0] cfg_data,
    output logic       cfg_wr,
    input  logic       cfg_busy,
    input  logic [7:0] status_in,
    output logic       frame_err
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, DISCARD} state_t;

    localparam logic [11:0] TO_LIM = 12'(TIMEOUT);
    localparam logic [11:0] TO_M1  = 12'(TIMEOUT - 1);
    localparam logic [7:0]  CMD_WR = 8'h57;
    localparam logic [7:0]  CMD_RD = 8'h52;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sck_last_q, sck_last_d;
    logic                   cs_last_q, cs_last_d;

    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  tx_q, tx_d;
    logic        miso_q, miso_d;
    logic [11:0] idle_q, idle_d;
    logic        is_wr_q, is_wr_d;
    logic        pend_q, pend_d;
    logic [7:0]  cfg_addr_q, cfg_addr_d;
    logic [7:0]  cfg_data_q, cfg_data_d;
    logic        err_q, err_d;

    // Synchronized views and edge events
    logic       sck_s, cs_s, mosi_s;
    logic       sck_rise, sck_fall, cs_rise, cs_fall;
    logic       bit_adv, byte_done, wr_issue, timeout_hit, active_st;
    logic [2:0] cnt_after;
    logic [7:0] rx_byte;

    // Synchronizer chains shift the raw pins in at the low end
    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        sck_s       = sck_sync_q[SYNC_STAGES-1];
        cs_s        = cs_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        sck_last_d  = sck_s;
        cs_last_d   = cs_s;
    end

    // Edge detection and per-cycle events. A bit is only taken if CS was
    // already active, so a byte finishing together with CS rise still counts.
    always_comb begin
        sck_rise    = sck_s & ~sck_last_q;
        sck_fall    = ~sck_s & sck_last_q;
        cs_fall     = ~cs_s & cs_last_q;
        cs_rise     = cs_s & ~cs_last_q;
        bit_adv     = sck_rise & ~cs_last_q;
        byte_done   = bit_adv & (bit_cnt_q == 3'd7);
        cnt_after   = bit_adv ? bit_cnt_q + 3'd1 : bit_cnt_q;
        rx_byte     = {rx_q[6:0], mosi_s};
        wr_issue    = pend_q & ~cfg_busy;
        active_st   = (state_q == CMD) || (state_q == ADDR) ||
                      (state_q == WDATA) || (state_q == RDATA);
        timeout_hit = ~cs_s & ~sck_rise & ~sck_fall & (idle_q == TO_M1) & active_st;
    end

    // State register
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; CS rise wins over everything, after the byte is used
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = CMD;
            CMD:     if (byte_done)
                         state_d = (rx_byte == CMD_WR || rx_byte == CMD_RD) ? ADDR : DISCARD;
            ADDR:    if (byte_done)
                         state_d = pend_q ? DISCARD : (is_wr_q ? WDATA : RDATA);
            WDATA:   if (byte_done && pend_q) state_d = DISCARD;
            RDATA:   state_d = RDATA;
            DISCARD: state_d = DISCARD;
            default: state_d = IDLE;
        endcase
        if (timeout_hit) state_d = DISCARD;
        if (cs_rise)     state_d = IDLE;
    end

    // Datapath: bit/idle counters, shift registers, write pending, errors.
    // A new address or data byte arriving while a write is still pending is
    // dropped as an overrun so cfg_addr/cfg_data never move under a pending write.
    always_comb begin
        bit_cnt_d  = cs_s ? 3'd0 : cnt_after;
        rx_d       = bit_adv ? rx_byte : rx_q;
        tx_d       = tx_q;
        miso_d     = miso_q;
        is_wr_d    = is_wr_q;
        pend_d     = pend_q;
        cfg_addr_d = cfg_addr_q;
        cfg_data_d = cfg_data_q;
        err_d      = 1'b0;

        if (cs_s || sck_rise || sck_fall) idle_d = 12'd0;
        else if (idle_q != TO_LIM)        idle_d = idle_q + 12'd1;
        else                              idle_d = idle_q;

        if (wr_issue) begin
            pend_d     = 1'b0;
            cfg_addr_d = cfg_addr_q + 8'd1;
        end

        if (sck_fall && !cs_s) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b1};
        end

        if (byte_done) begin
            case (state_q)
                CMD: begin
                    if (rx_byte == CMD_WR)      is_wr_d = 1'b1;
                    else if (rx_byte == CMD_RD) is_wr_d = 1'b0;
                    else                        err_d   = 1'b1;
                end
                ADDR: begin
                    if (pend_q) err_d = 1'b1;
                    else begin
                        cfg_addr_d = rx_byte;
                        if (!is_wr_q) tx_d = (rx_byte == 8'h00) ? status_in : 8'hFF;
                    end
                end
                WDATA: begin
                    if (pend_q) err_d = 1'b1;
                    else begin
                        cfg_data_d = rx_byte;
                        pend_d     = 1'b1;
                    end
                end
                RDATA:   tx_d = 8'hFF;
                default: ;
            endcase
        end

        if (timeout_hit)                      err_d = 1'b1;
        if (cs_rise && (cnt_after != 3'd0))   err_d = 1'b1;
    end

    // Datapath registers; synchronizers reset to the bus idle levels
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_last_q  <= 1'b0;
            cs_last_q   <= 1'b1;
            bit_cnt_q   <= 3'd0;
            rx_q        <= 8'h00;
            tx_q        <= 8'hFF;
            miso_q      <= 1'b1;
            idle_q      <= 12'd0;
            is_wr_q     <= 1'b0;
            pend_q      <= 1'b0;
            cfg_addr_q  <= 8'h00;
            cfg_data_q  <= 8'h00;
            err_q       <= 1'b0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_last_q  <= sck_last_d;
            cs_last_q   <= cs_last_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            idle_q      <= idle_d;
            is_wr_q     <= is_wr_d;
            pend_q      <= pend_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_data_q  <= cfg_data_d;
            err_q       <= err_d;
        end
    end

    // Outputs; MISO idles high outside an active read phase
    always_comb begin
        spi_miso  = (state_q == RDATA && !cs_s) ? miso_q : 1'b1;
        cfg_addr  = cfg_addr_q;
        cfg_data  = cfg_data_q;
        cfg_wr    = wr_issue;
        frame_err = err_q;
    end

endmodule
